// File: rtl/alu_pkg.sv
// Shared ALU definitions: widths, flag bit positions and opcode tags.
// Latency: n/a (constants and types only).
// Backpressure: n/a.
package alu_pkg;

    localparam int ALU_W  = 64;
    localparam int SEL_W  = 6;
    localparam int FLAG_W = 7;

    // Bit positions inside the ALU flag vector
    localparam int FLG_CARRY = 0;
    localparam int FLG_OVF   = 1;
    localparam int FLG_ZERO  = 2;
    localparam int FLG_NEG   = 3;
    localparam int FLG_PAR   = 4;
    localparam int FLG_MOD   = 5;
    localparam int FLG_SIGN  = 6;

    // Opcode tags shared by the ALU, this buffer and the consumer (OP_ADD=0 .. OP_GE=34)
    typedef enum logic [SEL_W-1:0] {
        OP_ADD = 6'd0, OP_SUB, OP_ADC, OP_SBB,
        OP_AND, OP_OR, OP_XOR, OP_NOT, OP_NAND, OP_NOR, OP_XNOR,
        OP_SLL, OP_SRL, OP_SRA, OP_ROL, OP_ROR,
        OP_MUL, OP_MULH, OP_MULHU, OP_MULHSU,
        OP_DIV, OP_DIVU, OP_REM, OP_REMU,
        OP_NEG, OP_ABS, OP_MIN, OP_MAX, OP_MINU, OP_MAXU,
        OP_EQ, OP_NE, OP_LT, OP_LTU, OP_GE
    } alu_op_e;

endpackage

// File: rtl/alu_result_mem.sv
// Entry storage for the ALU result buffer: one write port, one asynchronous read port, no reset.
// Latency: write lands on the clock edge; read is combinational from the addressed register.
// Backpressure: none; the caller only enables writes when a slot is free.
module alu_result_mem #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     wr_en,
    input  logic [$clog2(DEPTH)-1:0] wr_addr,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic [$clog2(DEPTH)-1:0] rd_addr,
    output logic [WIDTH-1:0]         rd_data
);

    logic [WIDTH-1:0] mem [DEPTH];

    // Capture an accepted entry; contents are don't-care until written
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/alu_result_fifo.sv
// Registered DEPTH-entry buffer behind the ALU, plus a sticky OR of all accepted flags.
// Latency: entry pushed at edge N is visible on out_* after edge N; no bypass path.
// Backpressure: in_ready = not full, from state only; a pop on a full FIFO re-opens in_ready next cycle.
module alu_result_fifo
    import alu_pkg::*;
#(
    parameter int DEPTH  = 4,
    parameter int DATA_W = ALU_W
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [SEL_W-1:0]         in_sel,
    input  logic [DATA_W-1:0]        in_result,
    input  logic [DATA_W-1:0]        in_upper,
    input  logic [FLAG_W-1:0]        in_flags,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [SEL_W-1:0]         out_sel,
    output logic [DATA_W-1:0]        out_result,
    output logic [DATA_W-1:0]        out_upper,
    output logic [FLAG_W-1:0]        out_flags,
    output logic [$clog2(DEPTH):0]   count,
    output logic [FLAG_W-1:0]        sticky_flags,
    input  logic                     sticky_clr
);

    localparam int AW      = $clog2(DEPTH);
    localparam int ENTRY_W = SEL_W + 2*DATA_W + FLAG_W;

    // Pointers carry one extra wrap bit so full and empty are distinguishable
    logic [AW:0]          wr_ptr;
    logic [AW:0]          rd_ptr;
    logic                 full;
    logic                 empty;
    logic                 push;
    logic                 pop;
    logic [ENTRY_W-1:0]   wr_data;
    logic [ENTRY_W-1:0]   rd_data;

    assign full  = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
    assign empty = (wr_ptr == rd_ptr);

    assign in_ready  = !full;
    assign out_valid = !empty;
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

    // Pointer difference modulo 2*DEPTH is exactly the occupancy 0..DEPTH
    assign count = wr_ptr - rd_ptr;

    // Advance write pointer on push, read pointer on pop; both wrap naturally
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

    assign wr_data = {in_sel, in_result, in_upper, in_flags};

    alu_result_mem #(
        .DEPTH (DEPTH),
        .WIDTH (ENTRY_W)
    ) u_mem (
        .clk     (clk),
        .wr_en   (push),
        .wr_addr (wr_ptr[AW-1:0]),
        .wr_data (wr_data),
        .rd_addr (rd_ptr[AW-1:0]),
        .rd_data (rd_data)
    );

    // Head fields are forced to zero while empty so stale storage never leaks out
    assign {out_sel, out_result, out_upper, out_flags} = out_valid ? rd_data : '0;

    // Sticky flag accumulation; a clear coinciding with a push keeps that push's flags
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sticky_flags <= '0;
        end else if (sticky_clr && push) begin
            sticky_flags <= in_flags;
        end else if (sticky_clr) begin
            sticky_flags <= '0;
        end else if (push) begin
            sticky_flags <= sticky_flags | in_flags;
        end
    end

endmodule

// File: tb/tb_alu_result_fifo.sv
// Scoreboard bench for alu_result_fifo: directed pushes queue expected entries, a monitor checks the head.
// Latency: n/a.
// Backpressure: stimulus drives out_ready explicitly per scenario.
module tb_alu_result_fifo;
    import alu_pkg::*;

    localparam int DEPTH   = 4;
    localparam int DATA_W  = 64;
    localparam int ENTRY_W = SEL_W + 2*DATA_W + FLAG_W;

    logic                   clk;
    logic                   rst;
    logic                   in_valid;
    logic                   in_ready;
    logic [SEL_W-1:0]       in_sel;
    logic [DATA_W-1:0]      in_result;
    logic [DATA_W-1:0]      in_upper;
    logic [FLAG_W-1:0]      in_flags;
    logic                   out_valid;
    logic                   out_ready;
    logic [SEL_W-1:0]       out_sel;
    logic [DATA_W-1:0]      out_result;
    logic [DATA_W-1:0]      out_upper;
    logic [FLAG_W-1:0]      out_flags;
    logic [$clog2(DEPTH):0] count;
    logic [FLAG_W-1:0]      sticky_flags;
    logic                   sticky_clr;

    alu_result_fifo #(.DEPTH(DEPTH), .DATA_W(DATA_W)) dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_sel       (in_sel),
        .in_result    (in_result),
        .in_upper     (in_upper),
        .in_flags     (in_flags),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_sel      (out_sel),
        .out_result   (out_result),
        .out_upper    (out_upper),
        .out_flags    (out_flags),
        .count        (count),
        .sticky_flags (sticky_flags),
        .sticky_clr   (sticky_clr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    logic mon_en = 1'b0;

    // Reference state
    logic [ENTRY_W-1:0] exp_q [$];
    int                 mcount = 0;
    logic [FLAG_W-1:0]  msticky = '0;

    task automatic check(input string name, input logic [159:0] act, input logic [159:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [SEL_W-1:0] sel, input logic [DATA_W-1:0] res,
                         input logic [DATA_W-1:0] up, input logic [FLAG_W-1:0] fl);
        in_valid  = v;
        in_sel    = sel;
        in_result = res;
        in_upper  = up;
        in_flags  = fl;
    endtask

    // One clock: check status against the model at negedge, update model, return #1 after posedge
    task automatic tick();
        logic do_push;
        logic do_pop;
        @(negedge clk);
        check("count", count, mcount);
        check("in_ready", in_ready, mcount != DEPTH);
        check("out_valid", out_valid, mcount != 0);
        check("sticky", sticky_flags, msticky);
        do_push = in_valid && (mcount != DEPTH);
        do_pop  = out_ready && (mcount != 0);
        if (do_push) exp_q.push_back({in_sel, in_result, in_upper, in_flags});
        if (sticky_clr && do_push) msticky = in_flags;
        else if (sticky_clr)       msticky = '0;
        else if (do_push)          msticky = msticky | in_flags;
        mcount = mcount + (do_push ? 1 : 0) - (do_pop ? 1 : 0);
        @(posedge clk);
        #1;
    endtask

    // Monitor: head must match the oldest expected entry, or be all zero when empty
    always @(negedge clk) begin
        if (mon_en) begin
            if (out_valid) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_valid: got out_valid=1 result=%0h expected no entry", out_result);
                end else begin
                    check("head", {out_sel, out_result, out_upper, out_flags}, exp_q[0]);
                    if (out_ready) exp_q.delete(0);
                end
            end else begin
                check("empty_head_zero", {out_sel, out_result, out_upper, out_flags}, '0);
            end
        end
    end

    initial begin
        rst = 1'b1; out_ready = 1'b0; sticky_clr = 1'b0;
        drive(1'b0, '0, '0, '0, '0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        mon_en = 1'b1;

        // Reset / idle
        check("rst_count", count, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_in_ready", in_ready, 1);
        check("rst_out_result", out_result, 0);
        check("rst_sticky", sticky_flags, 0);
        tick(); tick();

        // Single push, held three cycles without consumer
        drive(1'b1, OP_ADD, 64'h5, 64'h0, 7'h00);
        tick();
        in_valid = 1'b0;
        check("single_valid", out_valid, 1);
        check("single_result", out_result, 64'h5);
        check("single_count", count, 1);
        repeat (3) tick();
        check("single_hold", out_result, 64'h5);
        out_ready = 1'b1; tick(); out_ready = 1'b0;
        check("single_drained", count, 0);

        // Fill to DEPTH, a fifth offer is ignored, then drain in order
        for (int i = 1; i <= DEPTH; i++) begin
            drive(1'b1, OP_SUB, 64'(i), 64'(i) << 32, 7'h00);
            tick();
        end
        check("full_in_ready", in_ready, 0);
        check("full_count", count, 4);
        drive(1'b1, OP_SUB, 64'h5, 64'h0, 7'h00);
        tick();
        check("full_ignore_count", count, 4);
        in_valid = 1'b0; out_ready = 1'b1;
        repeat (4) tick();
        out_ready = 1'b0;
        check("drain_valid", out_valid, 0);
        check("drain_count", count, 0);

        // Full with both handshakes offered: pop first, push on following cycle
        for (int i = 0; i < DEPTH; i++) begin
            drive(1'b1, OP_MUL, 64'(20 + i), 64'(i + 1), 7'h00);
            tick();
        end
        drive(1'b1, OP_MULH, 64'd24, 64'hFFFF_0000_0000_0001, 7'h00);
        out_ready = 1'b1;
        tick();
        check("fullpop_count", count, 3);
        check("fullpop_in_ready", in_ready, 1);
        out_ready = 1'b0;
        tick();
        check("refill_count", count, 4);
        in_valid = 1'b0; out_ready = 1'b1;
        repeat (4) tick();
        out_ready = 1'b0;
        check("refill_drained", count, 0);

        // Streaming: one in, one out per cycle
        drive(1'b1, OP_XOR, 64'd10, 64'h0, 7'h00);
        tick();
        out_ready = 1'b1;
        for (int r = 11; r <= 19; r++) begin
            drive(1'b1, OP_XOR, 64'(r), 64'h0, 7'h00);
            tick();
            check("stream_count", count, 1);
        end
        in_valid = 1'b0;
        tick();
        out_ready = 1'b0;
        check("stream_done", count, 0);

        // Sticky flags accumulate, then clear-with-push keeps only new flags
        drive(1'b1, OP_ADD, 64'hA, 64'h0, 7'h01); tick();
        drive(1'b1, OP_ADD, 64'hB, 64'h0, 7'h04); tick();
        in_valid = 1'b0;
        check("sticky_or", sticky_flags, 7'h05);
        sticky_clr = 1'b1;
        drive(1'b1, OP_GE, 64'hC, 64'h0, 7'h40); tick();
        sticky_clr = 1'b0; in_valid = 1'b0;
        check("sticky_clr_push", sticky_flags, 7'h40);
        check("pre_reset_count", count, 3);

        // Asynchronous reset mid-stream empties everything at once
        rst = 1'b1;
        #1;
        check("midrst_count", count, 0);
        check("midrst_valid", out_valid, 0);
        check("midrst_sticky", sticky_flags, 0);
        check("midrst_result", out_result, 0);
        exp_q.delete();
        mcount = 0;
        msticky = '0;
        @(posedge clk);
        #1 rst = 1'b0;
        tick(); tick();

        mon_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
